// File: rtl/mul_accumulate_stage.sv
// mul_accumulate_stage: CryptoNight post-multiply stage; swapped-half add into a, XOR with scratchpad, handshake next a downstream
module mul_accumulate_stage #(
  parameter int ADDR_W = 17,
  parameter int ITERATIONS = 524288,
  parameter int CNT_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init_valid,
  input  logic [127:0]      init_a,
  input  logic              prod_valid,
  input  logic [127:0]      product,
  input  logic [127:0]      spad_data,
  output logic              wr_valid,
  output logic [127:0]      wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      a_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic [CNT_W-1:0]  iter_count,
  output logic              busy,
  output logic              done,
  output logic              overflow
);
  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;
  state_t state;
  logic [127:0] a, sum;
  logic [CNT_W:0] cnt_nx;
  logic hs, accept, last;
  always_comb begin
    sum = {a[127:64] + product[63:0], a[63:0] + product[127:64]};
    cnt_nx = {1'b0, iter_count} + (CNT_W+1)'(1);
    last = cnt_nx == (CNT_W+1)'(ITERATIONS);
    hs = out_valid & out_ready;
    // a product arriving on the cycle HOLD is released is taken back-to-back
    accept = prod_valid & (state == RUN | (state == HOLD & hs));
  end
  assign a_out = a;
  assign addr_out = a[ADDR_W+3:4];
  assign busy = state == RUN || state == HOLD;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a <= '0;
      wr_valid <= 1'b0;
      wr_data <= '0;
      out_valid <= 1'b0;
      iter_count <= '0;
      done <= 1'b0;
      overflow <= 1'b0;
    end else if (init_valid) begin
      state <= RUN;
      a <= init_a;
      wr_valid <= 1'b0;
      out_valid <= 1'b0;
      iter_count <= '0;
      done <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr_valid <= accept;
      if (accept) begin
        wr_data <= sum;
        a <= sum ^ spad_data;
        out_valid <= 1'b1;
        iter_count <= cnt_nx[CNT_W-1:0];
        state <= last ? DONE : HOLD;
        if (last) done <= 1'b1;
      end else begin
        if (hs) out_valid <= 1'b0;
        if (hs && state == HOLD) state <= RUN;
        if (prod_valid && state == HOLD) overflow <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mul_accumulate_stage.sv
// tb_mul_accumulate_stage: directed scoreboard bench for mul_accumulate_stage
module tb_mul_accumulate_stage;
  logic clk = 0, reset = 1, init_valid = 0, prod_valid = 0, out_ready = 0;
  logic [127:0] init_a = '0, product = '0, spad_data = '0;
  logic wr_valid, out_valid, busy, done, overflow;
  logic [127:0] wr_data, a_out;
  logic [16:0] addr_out;
  logic [4:0] iter_count;
  logic s_wr_valid, s_out_valid, s_busy, s_done, s_overflow;
  logic [127:0] s_wr_data, s_a_out;
  logic [16:0] s_addr_out;
  logic [2:0] s_iter_count;
  int errors = 0, checks = 0, pulses = 0, p0;
  logic [127:0] model_a = '0;
  logic [255:0] q[$];

  always #5 clk = ~clk;

  mul_accumulate_stage #(.ADDR_W(17), .ITERATIONS(16), .CNT_W(5)) dut (
    .clk(clk), .reset(reset), .init_valid(init_valid), .init_a(init_a),
    .prod_valid(prod_valid), .product(product), .spad_data(spad_data),
    .wr_valid(wr_valid), .wr_data(wr_data), .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .addr_out(addr_out), .iter_count(iter_count), .busy(busy),
    .done(done), .overflow(overflow));

  mul_accumulate_stage #(.ADDR_W(17), .ITERATIONS(4), .CNT_W(3)) u_small (
    .clk(clk), .reset(reset), .init_valid(init_valid), .init_a(init_a),
    .prod_valid(prod_valid), .product(product), .spad_data(spad_data),
    .wr_valid(s_wr_valid), .wr_data(s_wr_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .a_out(s_a_out), .addr_out(s_addr_out), .iter_count(s_iter_count), .busy(s_busy),
    .done(s_done), .overflow(s_overflow));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic init(input logic [127:0] x);
    init_a = x;
    init_valid = 1;
    tick;
    init_valid = 0;
    model_a = x;
  endtask

  task automatic send(input logic [127:0] p, input logic [127:0] s);
    logic [127:0] w;
    w = {model_a[127:64] + p[63:0], model_a[63:0] + p[127:64]};
    q.push_back({w, w ^ s});
    model_a = w ^ s;
    product = p;
    spad_data = s;
    prod_valid = 1;
    tick;
    prod_valid = 0;
  endtask

  task automatic handshake;
    out_ready = 1;
    tick;
    out_ready = 0;
  endtask

  // scoreboard: every write-back pulse must match the oldest expected result
  always @(negedge clk) begin
    if (wr_valid) begin
      pulses++;
      if (q.size() == 0) chk("sb_unexpected_wr", 128'(wr_valid), 128'd0);
      else begin
        logic [255:0] e;
        e = q.pop_front();
        chk("sb_wr_data", wr_data, e[255:128]);
        chk("sb_a_out", a_out, e[127:0]);
      end
    end
  end

  initial begin
    tick;
    tick;
    reset = 0;
    chk("rst_wr_valid", 128'(wr_valid), 0);
    chk("rst_out_valid", 128'(out_valid), 0);
    chk("rst_a_out", a_out, 0);
    chk("rst_iter", 128'(iter_count), 0);
    chk("rst_busy", 128'(busy), 0);
    chk("rst_flags", {done, overflow}, 0);

    init({64'h1, 64'h2});
    chk("init_busy", 128'(busy), 1);
    chk("init_a_out", a_out, {64'h1, 64'h2});
    send({64'h10, 64'h20}, {64'h1, 64'h1});
    chk("basic_wr_valid", 128'(wr_valid), 1);
    chk("basic_wr_data", wr_data, {64'h21, 64'h12});
    chk("basic_a_out", a_out, {64'h20, 64'h13});
    chk("basic_addr", 128'(addr_out), 1);
    chk("basic_iter", 128'(iter_count), 1);
    chk("basic_out_valid", 128'(out_valid), 1);
    tick;
    chk("basic_wr_pulse", 128'(wr_valid), 0);
    chk("basic_hold_valid", 128'(out_valid), 1);
    handshake;
    chk("basic_hs_drop", 128'(out_valid), 0);

    init({64'h0, 64'hFFFF_FFFF_FFFF_FFFF});
    send({64'h2, 64'h0}, '0);
    chk("wrap_wr_data", wr_data, {64'h0, 64'h1});
    handshake;

    init({64'h0123_4567_89ab_cdef, 64'hfedc_ba98_7654_3210});
    send({64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888}, {64'hdead_beef_0000_0001, 64'h0000_0000_cafe_f00d});
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        product = {$urandom, $urandom, $urandom, $urandom};
        prod_valid = 1;
      end
      tick;
      prod_valid = 0;
      chk("bp_out_valid", 128'(out_valid), 1);
      chk("bp_a_out", a_out, model_a);
      chk("bp_addr", 128'(addr_out), 128'(model_a[20:4]));
      if (i == 2) begin
        chk("bp_overflow", 128'(overflow), 1);
        chk("bp_iter", 128'(iter_count), 1);
      end
      if (i == 3) chk("bp_no_wr", 128'(wr_valid), 0);
    end
    handshake;
    chk("bp_release", 128'(out_valid), 0);

    init(128'h5a5a_0f0f_1234_5678_9abc_def0_1357_9bdf);
    p0 = pulses;
    out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
      tick;
    end
    out_ready = 0;
    chk("b2b_pulses", 128'(pulses - p0), 8);
    chk("b2b_iter", 128'(iter_count), 8);
    chk("b2b_overflow", 128'(overflow), 0);
    chk("b2b_done", 128'(done), 0);

    init(128'h77);
    for (int i = 0; i < 4; i++) begin
      send({$urandom, $urandom, $urandom, $urandom}, 128'(i));
      chk("done_timing", 128'(s_done), 128'(i == 3));
      handshake;
    end
    chk("done_iter", 128'(s_iter_count), 4);
    chk("done_busy", 128'(s_busy), 0);
    chk("done_delivered", 128'(s_out_valid), 0);
    send(128'h99, 128'h0);
    chk("done_ignore_wr", 128'(s_wr_valid), 0);
    chk("done_ignore_iter", 128'(s_iter_count), 4);
    chk("done_no_overflow", 128'(s_overflow), 0);
    chk("done_sticky", 128'(s_done), 1);
    handshake;

    init(128'h3);
    send(128'h1_0000_0000_0000_0000, 128'h0);
    reset = 1;
    tick;
    reset = 0;
    chk("mid_rst_wr_valid", 128'(wr_valid), 0);
    chk("mid_rst_outs", {wr_data[0], out_valid, done, overflow, busy}, 0);
    chk("mid_rst_a", a_out, 0);
    chk("mid_rst_iter", 128'(iter_count), 0);
    tick;
    chk("mid_rst_no_wr", 128'(wr_valid), 0);

    init(128'hABCD);
    send(128'h1, 128'h0);
    handshake;
    init_a = 128'h1234_5678;
    init_valid = 1;
    prod_valid = 1;
    product = 128'hFFFF;
    tick;
    init_valid = 0;
    prod_valid = 0;
    chk("coll_a", a_out, 128'h1234_5678);
    chk("coll_iter", 128'(iter_count), 0);
    chk("coll_wr", 128'(wr_valid), 0);
    chk("coll_busy", 128'(busy), 1);
    tick;
    chk("sb_drained", 128'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
